// File: rtl/scalar_mult_sched.sv
// scalar_mult_sched
//   Left-to-right double-and-add sequencer for k*P. A scalar is latched on
//   start and scanned MSB-first. Leading zeros are skipped one bit per cycle.
//   At the first set bit a LOAD is issued. Each following bit gets a DBL, and
//   also an ADD when that bit is set. Only one command is in flight at a time.
//
// Ports
//   i_clk       clock, rising edge
//   i_rst       synchronous active-high reset
//   i_start     start pulse, accepted only when idle
//   i_k         scalar, latched on accepted start
//   i_op_done   point-op unit finished the current command
//   o_op_req    1-cycle command strobe
//   o_op_sel    command: 00 LOAD, 01 DBL, 10 ADD
//   o_bit_idx   key bit currently being processed
//   o_busy      ladder in progress
//   o_done      1-cycle completion pulse
//   o_zero      k was zero (valid with o_done, held until next start)
module scalar_mult_sched #(
  parameter int KEY_W = 32,
  parameter int IDX_W = 5
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [KEY_W-1:0] i_k,
  input  logic             i_op_done,
  output logic             o_op_req,
  output logic [1:0]       o_op_sel,
  output logic [IDX_W-1:0] o_bit_idx,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_zero
);

  typedef enum logic [2:0] {IDLE, SCAN, ISSUE, WAIT, DONE} state_t;

  localparam logic [1:0]       OP_LOAD = 2'b00;
  localparam logic [1:0]       OP_DBL  = 2'b01;
  localparam logic [1:0]       OP_ADD  = 2'b10;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(KEY_W - 1);

  state_t           state;
  logic [KEY_W-1:0] k_r;
  logic             cur_bit;
  logic             last_bit;

  // o_bit_idx doubles as the scan pointer. o_op_sel doubles as the
  // current-command register, so it naturally holds through WAIT.
  assign cur_bit  = k_r[o_bit_idx];
  assign last_bit = (o_bit_idx == '0);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= IDLE;
      k_r       <= '0;
      o_op_req  <= 1'b0;
      o_op_sel  <= OP_LOAD;
      o_bit_idx <= '0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
      o_zero    <= 1'b0;
    end else begin
      o_op_req <= 1'b0;
      o_done   <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            k_r       <= i_k;
            o_bit_idx <= IDX_TOP;
            o_busy    <= 1'b1;
            o_zero    <= 1'b0;
            state     <= SCAN;
          end
        end
        SCAN: begin
          if (cur_bit) begin
            o_op_sel <= OP_LOAD;
            o_op_req <= 1'b1;
            state    <= ISSUE;
          end else if (last_bit) begin
            // All bits are zero. The result is the point at infinity and no
            // command is issued.
            o_zero <= 1'b1;
            o_done <= 1'b1;
            o_busy <= 1'b0;
            state  <= DONE;
          end else begin
            o_bit_idx <= o_bit_idx - 1'b1;
          end
        end
        ISSUE: state <= WAIT;
        WAIT: begin
          // Done pulses outside WAIT fall through the other states untouched.
          if (i_op_done) begin
            if (o_op_sel == OP_DBL && cur_bit) begin
              // The doubled bit is set, so add P at the same index.
              o_op_sel <= OP_ADD;
              o_op_req <= 1'b1;
              state    <= ISSUE;
            end else if (last_bit) begin
              o_done <= 1'b1;
              o_busy <= 1'b0;
              state  <= DONE;
            end else begin
              o_bit_idx <= o_bit_idx - 1'b1;
              o_op_sel  <= OP_DBL;
              o_op_req  <= 1'b1;
              state     <= ISSUE;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_scalar_mult_sched.sv
module tb_scalar_mult_sched;

  typedef struct {
    logic [1:0] sel;
    logic [4:0] idx;
  } op_t;

  typedef struct {
    logic [31:0] k;
    int          lat;
    logic        zero;
    int          nops;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] k_in;
  logic        resp_done;
  logic        spur;
  logic        op_done;
  logic        op_req;
  logic [1:0]  op_sel;
  logic [4:0]  bit_idx;
  logic        busy;
  logic        done;
  logic        zero;

  int total = 0;
  int bad   = 0;
  int op_cnt = 0;
  int done_cnt = 0;
  int opdone_cnt = 0;
  int outst = 0;
  int resp_lat = 1;
  int resp_en = 1;
  op_t exp_q[$];

  assign op_done = resp_done | spur;

  always #5 clk = ~clk;

  scalar_mult_sched #(.KEY_W(32), .IDX_W(5)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_k(k_in), .i_op_done(op_done),
    .o_op_req(op_req), .o_op_sel(op_sel), .o_bit_idx(bit_idx),
    .o_busy(busy), .o_done(done), .o_zero(zero)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  // Reference ladder: LOAD at the top set bit, then for every lower bit a
  // DBL followed by an ADD when that bit is set.
  task automatic push_expected(input logic [31:0] k);
    int m;
    op_t o;
    m = -1;
    for (int i = 31; i >= 0; i--)
      if (m < 0 && k[i]) m = i;
    if (m >= 0) begin
      o.sel = 2'b00; o.idx = 5'(m); exp_q.push_back(o);
      for (int i = m - 1; i >= 0; i--) begin
        o.sel = 2'b01; o.idx = 5'(i); exp_q.push_back(o);
        if (k[i]) begin
          o.sel = 2'b10; o.idx = 5'(i); exp_q.push_back(o);
        end
      end
    end
  endtask

  // Point-op responder: pulses done resp_lat cycles after each request.
  initial begin
    int pend;
    pend = 0;
    resp_done = 1'b0;
    forever begin
      @(negedge clk);
      resp_done = 1'b0;
      if (rst) pend = 0;
      else if (op_req && resp_en != 0) pend = resp_lat;
      else if (pend > 0) begin
        pend--;
        if (pend == 0) resp_done = 1'b1;
      end
    end
  end

  // Scoreboard monitor: pops the expected command for every request.
  initial begin
    op_t e;
    forever begin
      @(negedge clk);
      if (op_req) begin
        op_cnt++;
        chk("one_in_flight", 64'(outst), 64'd0);
        outst = 1;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_req got sel=%0d idx=%0d want none", op_sel, bit_idx);
        end else begin
          e = exp_q.pop_front();
          chk("op_sel", 64'(op_sel), 64'(e.sel));
          chk("bit_idx", 64'(bit_idx), 64'(e.idx));
        end
      end
      if (done) done_cnt++;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      if (op_done) begin
        outst = 0;
        opdone_cnt++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  task automatic wait_done(output int cyc, output bit got);
    cyc = 0;
    got = 0;
    while (!got && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (done) got = 1;
    end
    chk("done_seen", 64'(got), 64'd1);
  endtask

  task automatic wait_req();
    bit got;
    int cyc;
    got = 0;
    cyc = 0;
    while (!got && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (op_req) got = 1;
    end
    chk("req_seen", 64'(got), 64'd1);
  endtask

  task automatic run_k(input vec_t v);
    int oc, dc, odc, cyc;
    bit got;
    resp_lat = v.lat;
    push_expected(v.k);
    oc = op_cnt; dc = done_cnt; odc = opdone_cnt;
    @(posedge clk); #1;
    start = 1'b1; k_in = v.k;
    @(posedge clk); #1;
    start = 1'b0; k_in = $urandom;
    chk("busy", 64'(busy), 64'd1);
    wait_done(cyc, got);
    if (got) chk("zero", 64'(zero), 64'(v.zero));
    if (v.k == 32'd0) chk("zero_latency", 64'(cyc), 64'd33);
    repeat (3) @(posedge clk);
    #1;
    chk("op_count", 64'(op_cnt - oc), 64'(v.nops));
    chk("opdone_count", 64'(opdone_cnt - odc), 64'(v.nops));
    chk("done_count", 64'(done_cnt - dc), 64'd1);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);
    chk("zero_hold", 64'(zero), 64'(v.zero));
    exp_q.delete();
  endtask

  initial begin
    vec_t vecs[8];
    vec_t v;
    int oc, dc, cyc;
    bit got;

    vecs[0] = '{32'h0000_0005, 3, 1'b0, 4};
    vecs[1] = '{32'h0000_0000, 1, 1'b1, 0};
    vecs[2] = '{32'h8000_0000, 1, 1'b0, 32};
    vecs[3] = '{32'hFFFF_FFFF, 1, 1'b0, 63};
    vecs[4] = '{32'h0000_0001, 2, 1'b0, 1};
    vecs[5] = '{32'h0000_00A5, 2, 1'b0, 11};
    vecs[6] = '{32'h4000_0001, 1, 1'b0, 32};
    vecs[7] = '{32'h0000_0003, 3, 1'b0, 3};

    rst = 1'b1; start = 1'b0; k_in = '0; spur = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", 64'(op_req), 64'd0);
    chk("rst_sel", 64'(op_sel), 64'd0);
    chk("rst_idx", 64'(bit_idx), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_zero", 64'(zero), 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) run_k(vecs[i]);

    // Spurious op_done in IDLE and SCAN, and a second start while busy.
    resp_lat = 2;
    push_expected(32'h5);
    oc = op_cnt; dc = done_cnt;
    @(posedge clk); #1 spur = 1'b1;
    @(posedge clk); #1 spur = 1'b0;
    start = 1'b1; k_in = 32'h5;
    @(posedge clk); #1;
    start = 1'b1; k_in = 32'hFFFF_FFFF; spur = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; spur = 1'b0;
    wait_done(cyc, got);
    if (got) chk("spur_zero", 64'(zero), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("spur_op_count", 64'(op_cnt - oc), 64'd4);
    chk("spur_done_count", 64'(done_cnt - dc), 64'd1);
    chk("spur_queue_empty", 64'(exp_q.size()), 64'd0);
    exp_q.delete();

    // Reset in the WAIT that follows the DBL of k=3.
    resp_en = 0;
    v = '{32'h3, 1, 1'b0, 2};
    push_expected(v.k);
    void'(exp_q.pop_back());
    dc = done_cnt;
    @(posedge clk); #1;
    start = 1'b1; k_in = v.k;
    @(posedge clk); #1;
    start = 1'b0;
    wait_req();
    @(posedge clk); #1 spur = 1'b1;
    @(posedge clk); #1 spur = 1'b0;
    wait_req();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    outst = 0;
    chk("abort_req", 64'(op_req), 64'd0);
    chk("abort_sel", 64'(op_sel), 64'd0);
    chk("abort_idx", 64'(bit_idx), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_zero", 64'(zero), 64'd0);
    repeat (6) @(posedge clk);
    #1;
    chk("abort_no_done", 64'(done_cnt - dc), 64'd0);
    chk("abort_queue_empty", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    resp_en = 1;
    v = '{32'h3, 2, 1'b0, 3};
    run_k(v);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
